// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, FSM state encoding and divide-by-zero constant for div_issue_ctrl
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } div_state_t;

  // Quotient produced by div_16b when the divisor is zero.
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock request FIFO with occupancy count
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [DW-1:0]                  wdata,
  input  logic                           pop,
  output logic [DW-1:0]                  rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - buffers operand pairs, runs the div_16b start/ready handshake, holds one result
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_start,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  input  logic             div_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz,
  output logic             busy
);

  div_state_t state;
  div_state_t state_nxt;

  logic                               fifo_push;
  logic                               fifo_pop;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count;
  logic [2*WIDTH-1:0]                 fifo_rdata;
  logic [WIDTH-1:0]                   head_a;
  logic [WIDTH-1:0]                   head_b;

  logic dbz_pend;
  logic slot_free;
  logic issue;
  logic start_clr;
  logic capture;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = issue;
  assign {head_a, head_b} = fifo_rdata;

  sync_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A result being accepted this cycle frees the slot for the next issue.
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Issuing also waits on div_ready so a divider still busy from before a reset is never restarted.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    start_clr = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && div_ready && slot_free) begin
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!div_ready) begin
          start_clr = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (div_ready) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_a     <= '0;
      div_b     <= '0;
      div_start <= 1'b0;
      dbz_pend  <= 1'b0;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_dbz   <= 1'b0;
    end else begin
      if (issue) begin
        div_a     <= head_a;
        div_b     <= head_b;
        dbz_pend  <= (head_b == '0);
        div_start <= 1'b1;
      end else if (start_clr) begin
        div_start <= 1'b0;
      end

      if (capture) begin
        out_quot  <= div_quot;
        out_rem   <= div_rem;
        out_dbz   <= dbz_pend;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) || (fifo_count != '0) || out_valid;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl with a behavioural divider stand-in
module tb_div_issue_ctrl;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [W-1:0] div_a;
  logic [W-1:0] div_b;
  logic         div_start;
  logic [W-1:0] div_quot;
  logic [W-1:0] div_rem;
  logic         div_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
  logic         out_dbz;
  logic         busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_start (div_start),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .div_ready (div_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_quot  (out_quot),
    .out_rem   (out_rem),
    .out_dbz   (out_dbz),
    .busy      (busy)
  );

  // Multi-cycle divider stand-in with random latency and no reset, like div_16b.
  logic         dv_ready = 1'b1;
  int           dv_cnt = 0;
  int           dv_starts = 0;
  logic [W-1:0] dv_a = '0;
  logic [W-1:0] dv_b = '0;
  logic [W-1:0] dv_q = '0;
  logic [W-1:0] dv_r = '0;

  assign div_ready = dv_ready;
  assign div_quot  = dv_q;
  assign div_rem   = dv_r;

  always @(posedge clk) begin
    if (dv_ready) begin
      if (div_start) begin
        dv_ready  <= 1'b0;
        dv_cnt    <= int'($urandom_range(2, 6));
        dv_a      <= div_a;
        dv_b      <= div_b;
        dv_starts <= dv_starts + 1;
      end
    end else if (dv_cnt == 0) begin
      dv_ready <= 1'b1;
      dv_q     <= (dv_b == '0) ? '1 : dv_a / dv_b;
      dv_r     <= (dv_b == '0) ? dv_a : dv_a % dv_b;
    end else begin
      dv_cnt <= dv_cnt - 1;
    end
  end

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  res_t exp_q[$];
  bit   sb_en = 1'b0;
  bit   hold_en = 1'b1;
  int   accepted = 0;
  int   pushed = 0;
  int   start_hi = 0;

  function automatic res_t ref_div(logic [W-1:0] a, logic [W-1:0] b);
    res_t r;
    if (b == '0) begin
      r.q = '1;  r.r = a;  r.dbz = 1'b1;
    end else begin
      r.q = a / b;  r.r = a % b;  r.dbz = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already set; accounts for the next rising edge.
  task automatic cycle();
    res_t e;
    if (div_start) start_hi++;
    if (hold_en && !dv_ready) chk("operand_hold", {div_a, div_b}, {dv_a, dv_b});
    if (sb_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_quot", 32'(out_quot), 32'(e.q));
        chk("sb_rem",  32'(out_rem),  32'(e.r));
        chk("sb_dbz",  32'(out_dbz),  32'(e.dbz));
      end
    end
    if (out_valid && out_ready) accepted++;
    if (in_valid && in_ready) begin
      pushed++;
      if (sb_en) exp_q.push_back(ref_div(in_a, in_b));
    end
    @(negedge clk);
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      cycle();
      n++;
    end
    chk(name, 32'(n < 60), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      cycle();
      n++;
    end
    chk(name, 32'(n < 400), 32'd1);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  vec_t vec[6];

  initial begin
    int n, s0, acc0, p0;
    logic [W-1:0] sq, sr;

    vec[0] = '{a: 16'h1234, b: 16'h0010, q: 16'h0123, r: 16'h0004, dbz: 1'b0};
    vec[1] = '{a: 16'h0064, b: 16'h0000, q: 16'hFFFF, r: 16'h0064, dbz: 1'b1};
    vec[2] = '{a: 16'hFFFF, b: 16'h0001, q: 16'hFFFF, r: 16'h0000, dbz: 1'b0};
    vec[3] = '{a: 16'h0007, b: 16'h0009, q: 16'h0000, r: 16'h0007, dbz: 1'b0};
    vec[4] = '{a: 16'h8000, b: 16'h0003, q: 16'h2AAA, r: 16'h0002, dbz: 1'b0};
    vec[5] = '{a: 16'h0000, b: 16'h0000, q: 16'hFFFF, r: 16'h0000, dbz: 1'b1};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_ab",    {div_a, div_b}, 32'd0);
    chk("rst_out_qr",    {out_quot, out_rem}, 32'd0);
    chk("rst_out_dbz",   32'(out_dbz), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready), 32'd1);

    // Table-driven single jobs
    for (int i = 0; i < 6; i++) begin
      start_hi  = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = vec[i].a;
      in_b      = vec[i].b;
      cycle();
      in_valid = 1'b0;
      if (i == 0) begin
        chk("lat_n1_start", 32'(div_start), 32'd0);
        chk("lat_n1_busy",  32'(busy), 32'd1);
        cycle();
        chk("lat_n2_start", 32'(div_start), 32'd1);
        chk("lat_n2_div_a", 32'(div_a), 32'h1234);
        chk("lat_n2_div_b", 32'(div_b), 32'h0010);
      end
      wait_out("vec_timeout");
      chk("vec_quot", 32'(out_quot), 32'(vec[i].q));
      chk("vec_rem",  32'(out_rem),  32'(vec[i].r));
      chk("vec_dbz",  32'(out_dbz),  32'(vec[i].dbz));
      if (i == 0) chk("start_hi_cycles", start_hi, 2);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("vec_drained", 32'(out_valid), 32'd0);
      chk("vec_idle",    32'(busy), 32'd0);
    end

    // Backpressure: 7 back-to-back offers with the consumer stalled
    sb_en = 1'b1;
    s0 = dv_starts;
    p0 = pushed;
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_a = 16'($urandom);
      in_b = 16'($urandom_range(0, 300));
      cycle();
    end
    in_valid = 1'b0;
    chk("bp_accepted", pushed - p0, 5);
    wait_out("bp_timeout");
    sq = out_quot;
    sr = out_rem;
    for (int i = 0; i < 20; i++) cycle();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_stable", {out_quot, out_rem}, {sq, sr});
    chk("bp_starts", dv_starts - s0, 1);
    drain("bp_drain");

    // Ordering: 4 back-to-back random jobs
    acc0 = accepted;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_a = 16'($urandom);
      in_b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    n = 0;
    while (accepted - acc0 < 4 && n < 200) begin
      cycle();
      n++;
    end
    chk("ord_timeout", 32'(n < 200), 32'd1);
    chk("ord_busy_low", 32'(busy), 32'd0);
    chk("ord_sb_empty", 32'(exp_q.size()), 32'd0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_a      = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       in_b = 16'h0000;
        1:       in_b = 16'($urandom_range(1, 15));
        default: in_b = 16'($urandom);
      endcase
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain("rand_drain");

    // Simultaneous accept and issue
    out_ready = 1'b0;
    acc0 = accepted;
    in_valid = 1'b1; in_a = 16'h0500; in_b = 16'h0007;
    cycle();
    in_a = 16'h0400; in_b = 16'h0000;
    cycle();
    in_valid = 1'b0;
    wait_out("sim_timeout");
    for (int i = 0; i < 3; i++) cycle();
    chk("sim_no_issue", 32'(div_start), 32'd0);
    out_ready = 1'b1;
    cycle();
    chk("sim_dropped", 32'(out_valid), 32'd0);
    chk("sim_issued",  32'(div_start), 32'd1);
    chk("sim_div_b",   32'(div_b), 32'h0000);
    n = 0;
    while (accepted - acc0 < 2 && n < 60) begin
      cycle();
      n++;
    end
    chk("sim_timeout2", 32'(n < 60), 32'd1);
    for (int i = 0; i < 5; i++) cycle();
    chk("sim_once", accepted - acc0, 2);

    // Reset while the divider is busy
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h7777; in_b = 16'h0011;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while ((div_start || dv_ready) && n < 40) begin
      cycle();
      n++;
    end
    chk("rmid_reach_wait", 32'(n < 40), 32'd1);
    hold_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_out_valid", 32'(out_valid), 32'd0);
    chk("rmid_div_start", 32'(div_start), 32'd0);
    chk("rmid_div_ab",    {div_a, div_b}, 32'd0);
    chk("rmid_out_qr",    {out_quot, out_rem}, 32'd0);
    chk("rmid_busy",      32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    acc0 = accepted;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("rmid_no_stale", accepted - acc0, 0);
    chk("rmid_div_idle", 32'(dv_ready), 32'd1);
    hold_en = 1'b1;
    in_valid = 1'b1; in_a = 16'h0BB8; in_b = 16'h0007;
    cycle();
    in_valid = 1'b0;
    n = 0;
    while (accepted - acc0 < 1 && n < 60) begin
      cycle();
      n++;
    end
    chk("rmid_new_job", 32'(n < 60), 32'd1);
    chk("rmid_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Request sequencer that sits directly upstream of div_16b and drives its a/b/start inputs. It buffers operand pairs in a small FIFO and runs the divider's start/ready handshake, one job at a time. It captures quot/rem into a single-entry result register that is exposed with a valid/ready handshake, adding a divide-by-zero flag. Results leave in the same order the requests arrived.

Parameters:
WIDTH, 16, operand/result width; must match div_16b.
FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request present.
in_ready  output  1  FIFO not full (in_ready = count != FIFO_DEPTH).
in_a  input  WIDTH  dividend.
in_b  input  WIDTH  divisor.
div_a  output  WIDTH  to div_16b a; held stable from issue until result capture.
div_b  output  WIDTH  to div_16b b; same stability rule.
div_start  output  1  to div_16b start; registered.
div_quot  input  WIDTH  from div_16b quot.
div_rem  input  WIDTH  from div_16b rem.
div_ready  input  1  from div_16b ready; high = idle/result valid.
out_valid  output  1  result register full.
out_ready  input  1  consumer accepts.
out_quot  output  WIDTH  captured quotient.
out_rem  output  WIDTH  captured remainder.
out_dbz  output  1  divisor of this job was 0.
busy  output  1  state != IDLE or FIFO non-empty or out_valid.

Behaviour:
- Reset, asynchronous: FIFO emptied; state = IDLE; div_start = 0; div_a = div_b = 0; out_valid = 0; out_quot = out_rem = 0; out_dbz = 0; busy = 0; in_ready = 1 once reset is released.
- FIFO push: in_valid && in_ready. Pop: on the IDLE -> ISSUE transition only. A push and pop in the same cycle leave count unchanged. A push while full is impossible because in_ready = 0.
- Result slot is free when out_valid = 0, or when out_valid && out_ready in the current cycle.
- IDLE: go to ISSUE when FIFO is non-empty, div_ready = 1 and the result slot is free. On that transition, load head into div_a/div_b, latch dbz_pend = (head b == 0), and set div_start = 1.
- ISSUE: hold div_start = 1 until div_ready is sampled 0. Then set div_start = 0 and go to WAIT.
- WAIT: when div_ready is sampled 1, load out_quot <= div_quot, out_rem <= div_rem, out_dbz <= dbz_pend, out_valid <= 1, and go to IDLE.
- Output handshake: out_valid clears on out_valid && out_ready unless a capture occurs in the same cycle; capture wins and keeps the flag set. out_* hold stable while out_valid && !out_ready.
- Latency: request in an empty system at cycle N is pushed at N, the earliest pop/issue is at N+1, and div_start is visible at N+2. Result appears 1 cycle after div_ready rises.
- Divide by zero: the block does not special-case it. It passes through the divider result, which is quot = all-ones and rem = a, and flags out_dbz = 1.
- Reset mid-operation: all state is cleared. div_16b has no reset, so after reset the block must stay in IDLE until div_ready = 1 before issuing; no stale result is captured.
- At most one job is in the divider; a new issue never occurs while out_valid && !out_ready.

Decomposition:
- Package div_pkg: WIDTH default, state enum {IDLE, ISSUE, WAIT} (2-bit), and the all-ones divide-by-zero constant.
- Sub-module: sync_fifo (WIDTH*2 data, FIFO_DEPTH, clk/rst_n, push/pop/full/empty/count).
- FSM, operand registers and result register stay in div_issue_ctrl.

Test Plan:
- Single job: in_a = 0x1234, in_b = 0x0010, out_ready = 1 -> out_quot = 0x0123, out_rem = 0x0004, out_dbz = 0; div_start high from issue until div_ready falls.
- Zero divisor: in_a = 0x0064, in_b = 0 -> out_quot = 0xFFFF, out_rem = 0x0064, out_dbz = 1.
- Backpressure: out_ready = 0, push 7 requests back-to-back -> 5 are accepted (1 issued, 4 in FIFO) and in_ready = 0 thereafter. out_valid stays 1 with stable data and no second div_start.
- Ordering: 4 random pairs pushed back-to-back with out_ready = 1 -> 4 results in push order, each matching a/b and a%b (all-ones/a when b = 0); busy falls after the last accept.
- Reset mid-op: assert rst_n = 0 during WAIT -> all outputs are 0 immediately. After release, no output appears until a new request, which completes correctly.
- Simultaneous: out_valid && out_ready in the same cycle as the IDLE -> ISSUE check -> the next job issues that cycle, and the old result is dropped exactly once.
